// File: rtl/md5_block_sequencer.sv
// md5_block_sequencer: message-level controller between the chunk input stream,
// the md5_padding block and the md5 core. Full non-final chunks go straight to
// the core. The message tail goes through the padder, which yields one or two
// padded blocks. Every block reaches the core in order and is tagged first/last.
module md5_block_sequencer #(
  parameter int unsigned PAD_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           h_rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [0:511]   s_data,
  input  logic           s_last,
  input  logic [9:0]     s_bits,
  output logic           pad_h_rst,
  output logic           pad_s_rst,
  output logic [0:511]   pad_data,
  output logic [63:0]    pad_size,
  input  logic [0:511]   pad_block,
  input  logic [1:0]     pad_status,
  output logic           core_start,
  output logic [0:511]   core_block,
  output logic           core_first,
  output logic           core_last,
  input  logic           core_done,
  output logic           msg_done,
  output logic [63:0]    msg_len,
  output logic           err
);

  localparam int unsigned TW = $clog2(PAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PAD_TIMEOUT - 1);
  localparam logic [0:511]  ALL_ONES = '1;

  typedef enum logic [3:0] {
    IDLE,
    ACCEPT,
    RAW_GO,
    RAW_WAIT,
    PAD_LOAD,
    PAD_WAIT,
    PAD_CORE,
    PAD_NEXT,
    DONE
  } state_t;

  state_t        state;
  logic [63:0]   len;
  logic          first_pend;
  logic          tail_pend;
  logic [TW-1:0] tmo_cnt;
  logic [0:511]  keep_mask;
  logic          handshake;

  // Bits 0..s_bits-1 of a tail chunk survive; everything after is forced to zero.
  assign keep_mask = ~(ALL_ONES >> s_bits);
  assign handshake = s_valid && s_ready;

  // Message sequencing FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (!h_rst_n) begin
      state      <= IDLE;
      len        <= '0;
      first_pend <= 1'b1;
      tail_pend  <= 1'b0;
      tmo_cnt    <= '0;
      s_ready    <= 1'b0;
      pad_h_rst  <= 1'b0;
      pad_s_rst  <= 1'b0;
      pad_data   <= '0;
      pad_size   <= '0;
      core_start <= 1'b0;
      core_block <= '0;
      core_first <= 1'b0;
      core_last  <= 1'b0;
      msg_done   <= 1'b0;
      msg_len    <= '0;
      err        <= 1'b0;
    end else begin
      pad_h_rst  <= 1'b0;
      pad_s_rst  <= 1'b0;
      core_start <= 1'b0;
      msg_done   <= 1'b0;
      s_ready    <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          state   <= ACCEPT;
        end
        ACCEPT: begin
          if (handshake) begin
            if (!s_last) begin
              if (s_bits == 10'd512) begin
                len        <= len + 64'd512;
                core_block <= s_data;
                tail_pend  <= 1'b0;
                state      <= RAW_GO;
              end else begin
                // Malformed mid-message chunk: drop the whole message.
                err        <= 1'b1;
                len        <= '0;
                first_pend <= 1'b1;
                tail_pend  <= 1'b0;
                state      <= IDLE;
              end
            end else if (s_bits >= 10'd512) begin
              // Full final chunk: hash it raw, then pad an empty tail.
              len        <= len + 64'd512;
              core_block <= s_data;
              pad_data   <= '0;
              tail_pend  <= 1'b1;
              state      <= RAW_GO;
            end else begin
              len      <= len + {54'd0, s_bits};
              pad_data <= s_data & keep_mask;
              state    <= PAD_LOAD;
            end
          end else begin
            s_ready <= 1'b1;
          end
        end
        RAW_GO: begin
          core_start <= 1'b1;
          core_first <= first_pend;
          core_last  <= 1'b0;
          first_pend <= 1'b0;
          state      <= RAW_WAIT;
        end
        RAW_WAIT: begin
          if (core_done) begin
            if (tail_pend) begin
              tail_pend <= 1'b0;
              state     <= PAD_LOAD;
            end else begin
              s_ready <= 1'b1;
              state   <= ACCEPT;
            end
          end
        end
        PAD_LOAD: begin
          pad_h_rst <= 1'b1;
          pad_size  <= len;
          tmo_cnt   <= '0;
          state     <= PAD_WAIT;
        end
        PAD_WAIT: begin
          // While our own h_rst/s_rst pulse is out, the padder has not seen it
          // yet and pad_status still belongs to the previous request.
          if (pad_status != 2'b00 && !pad_h_rst && !pad_s_rst) begin
            core_block <= pad_block;
            core_start <= 1'b1;
            core_first <= first_pend;
            core_last  <= pad_status[0];
            first_pend <= 1'b0;
            state      <= PAD_CORE;
          end else if (tmo_cnt == TMO_LAST) begin
            err        <= 1'b1;
            len        <= '0;
            first_pend <= 1'b1;
            tail_pend  <= 1'b0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        PAD_CORE: begin
          if (core_done) begin
            state <= core_last ? DONE : PAD_NEXT;
          end
        end
        PAD_NEXT: begin
          pad_s_rst <= 1'b1;
          tmo_cnt   <= '0;
          state     <= PAD_WAIT;
        end
        DONE: begin
          msg_done   <= 1'b1;
          msg_len    <= len;
          len        <= '0;
          first_pend <= 1'b1;
          s_ready    <= 1'b1;
          state      <= ACCEPT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_block_sequencer.sv
// Bench for md5_block_sequencer: behavioural padder and core models, and a
// byte-level MD5 padding reference that predicts every block, pad load and
// message length from the raw message bytes.
module tb_md5_block_sequencer;

  localparam int unsigned PAD_TIMEOUT = 16;

  logic         clk;
  logic         h_rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [0:511] s_data;
  logic         s_last;
  logic [9:0]   s_bits;
  logic         pad_h_rst;
  logic         pad_s_rst;
  logic [0:511] pad_data;
  logic [63:0]  pad_size;
  logic [0:511] pad_block;
  logic [1:0]   pad_status;
  logic         core_start;
  logic [0:511] core_block;
  logic         core_first;
  logic         core_last;
  logic         core_done;
  logic         msg_done;
  logic [63:0]  msg_len;
  logic         err;

  md5_block_sequencer #(.PAD_TIMEOUT(PAD_TIMEOUT)) dut (
    .clk        (clk),
    .h_rst_n    (h_rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_bits     (s_bits),
    .pad_h_rst  (pad_h_rst),
    .pad_s_rst  (pad_s_rst),
    .pad_data   (pad_data),
    .pad_size   (pad_size),
    .pad_block  (pad_block),
    .pad_status (pad_status),
    .core_start (core_start),
    .core_block (core_block),
    .core_first (core_first),
    .core_last  (core_last),
    .core_done  (core_done),
    .msg_done   (msg_done),
    .msg_len    (msg_len),
    .err        (err)
  );

  typedef struct { logic [0:511] blk; logic first; logic last; int unsigned id; } blk_t;
  typedef struct { logic [0:511] data; logic [63:0] size; } pad_t;
  typedef struct { logic [63:0] len; int unsigned id; } len_t;

  blk_t        exp_blk_q[$];
  pad_t        exp_pad_q[$];
  len_t        exp_len_q[$];
  logic [7:0]  msg_bytes[$];
  int unsigned msg_id = 0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int unsigned done_cnt  = 0;
  int unsigned pad_s_cnt = 0;
  logic        core_busy = 1'b0;

  int unsigned pad_extra = 0;
  logic        pad_stuck = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural md5_padding: tail bytes, 0x80, zeros, 64-bit little-endian length.
  task automatic build_pad(input logic [0:511] d, input logic [63:0] sz,
                           output logic [0:511] b1, output logic [0:511] b2, output logic two);
    logic [7:0]  b[128];
    int unsigned tb;
    int unsigned lp;
    foreach (b[k]) b[k] = 8'h00;
    tb = {23'd0, sz[8:0]} >> 3;
    for (int unsigned k = 0; k < tb; k++) b[k] = d[8*k +: 8];
    b[tb] = 8'h80;
    two = (tb >= 56);
    lp = two ? 120 : 56;
    for (int unsigned j = 0; j < 8; j++) b[lp+j] = sz[8*j +: 8];
    for (int unsigned k = 0; k < 64; k++) begin
      b1[8*k +: 8] = b[k];
      b2[8*k +: 8] = b[64+k];
    end
  endtask

  // Padder model: reacts to h_rst/s_rst pulses with a random latency.
  initial begin
    logic [0:511] pb1;
    logic [0:511] pb2;
    logic         two;
    int unsigned  phase;
    int unsigned  cnt;
    pad_status = 2'b00;
    pad_block  = '0;
    pb1 = '0; pb2 = '0; two = 1'b0; phase = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (pad_h_rst) begin
        build_pad(pad_data, pad_size, pb1, pb2, two);
        pad_status = 2'b00;
        phase = 1;
        cnt = $urandom_range(0, 3) + pad_extra;
      end else if (pad_s_rst) begin
        pad_status = 2'b00;
        phase = 2;
        cnt = $urandom_range(0, 3) + pad_extra;
      end else if (phase != 0 && !pad_stuck) begin
        if (cnt == 0) begin
          if (phase == 1) begin
            pad_block  = pb1;
            pad_status = two ? 2'b10 : 2'b01;
          end else begin
            pad_block  = pb2;
            pad_status = 2'b11;
          end
          phase = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Core model plus output monitor, sampled on the falling edge.
  initial begin
    blk_t         eb;
    pad_t         ep;
    len_t         el;
    logic [0:511] held_blk;
    int unsigned  core_cnt;
    core_done = 1'b0;
    held_blk = '0;
    core_cnt = 0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!h_rst_n) begin
        core_busy = 1'b0;
        exp_blk_q.delete();
        exp_pad_q.delete();
        exp_len_q.delete();
      end else begin
        if (core_start) begin
          check_eq("start_expected", exp_blk_q.size() != 0, 1'b1);
          check_eq("core_idle_at_start", core_busy, 1'b0);
          check_eq("s_ready_low_at_start", s_ready, 1'b0);
          if (exp_blk_q.size() != 0) begin
            eb = exp_blk_q.pop_front();
            check_eq("core_block", core_block, eb.blk);
            check_eq("core_first", core_first, eb.first);
            check_eq("core_last", core_last, eb.last);
          end
          core_busy = 1'b1;
          core_cnt  = $urandom_range(1, 4);
          held_blk  = core_block;
        end else if (core_busy) begin
          core_cnt--;
          if (core_cnt == 0) begin
            check_eq("core_block_stable", core_block, held_blk);
            core_done = 1'b1;
            core_busy = 1'b0;
          end
        end
        if (pad_h_rst) begin
          check_eq("pad_load_expected", exp_pad_q.size() != 0, 1'b1);
          check_eq("s_ready_low_at_pad", s_ready, 1'b0);
          if (exp_pad_q.size() != 0) begin
            ep = exp_pad_q.pop_front();
            check_eq("pad_size", pad_size, ep.size);
            check_eq("pad_data", pad_data, ep.data);
          end
        end
        if (pad_s_rst) pad_s_cnt++;
        if (msg_done) begin
          done_cnt++;
          check_eq("done_expected", exp_len_q.size() != 0, 1'b1);
          if (exp_len_q.size() != 0) begin
            el = exp_len_q.pop_front();
            check_eq("msg_len", msg_len, el.len);
            check_eq("blocks_consumed",
                     (exp_blk_q.size() == 0) || (exp_blk_q[0].id != el.id), 1'b1);
          end
        end
      end
    end
  end

  task automatic do_reset();
    h_rst_n = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_bits  = '0;
    s_data  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_s_ready", s_ready, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_pulses", {core_start, msg_done, pad_h_rst, pad_s_rst}, 4'b0000);
    check_eq("rst_core_block", core_block, '0);
    check_eq("rst_pad_data", pad_data, '0);
    check_eq("rst_pad_size", pad_size, 64'd0);
    check_eq("rst_msg_len", msg_len, 64'd0);
    h_rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", s_ready, 1'b1);
  endtask

  // Presents one chunk and returns on the falling edge after it was taken; s_valid stays high.
  task automatic send_chunk(input logic [0:511] d, input logic last, input logic [9:0] bits);
    int unsigned n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_bits  = bits;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_timeout", n < 2000, 1'b1);
    @(negedge clk);
  endtask

  // Reference: MD5-pad the whole byte stream, split into blocks, then send the chunks.
  task automatic send_msg();
    logic [7:0]   p[$];
    logic [63:0]  len_bits;
    logic [0:511] v;
    int unsigned  n, nb, tail, nch, base, cnt;
    blk_t         eb;
    pad_t         ep;
    len_t         el;
    n = msg_bytes.size();
    len_bits = 64'(n) * 64'd8;
    p = msg_bytes;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int unsigned j = 0; j < 8; j++) p.push_back(len_bits[8*j +: 8]);
    nb = p.size() / 64;
    for (int unsigned b = 0; b < nb; b++) begin
      v = '0;
      for (int unsigned k = 0; k < 64; k++) v[8*k +: 8] = p[64*b + k];
      eb.blk = v;
      eb.first = (b == 0);
      eb.last = (b == nb - 1);
      eb.id = msg_id;
      exp_blk_q.push_back(eb);
    end
    tail = n % 64;
    v = '0;
    for (int unsigned k = 0; k < tail; k++) v[8*k +: 8] = msg_bytes[n - tail + k];
    ep.data = v;
    ep.size = len_bits;
    exp_pad_q.push_back(ep);
    el.len = len_bits;
    el.id  = msg_id;
    exp_len_q.push_back(el);
    nch = (n == 0) ? 1 : (n + 63) / 64;
    for (int unsigned c = 0; c < nch; c++) begin
      base = 64 * c;
      cnt = (n - base > 64) ? 64 : n - base;
      for (int unsigned w = 0; w < 16; w++) v[32*w +: 32] = $urandom();
      for (int unsigned k = 0; k < cnt; k++) v[8*k +: 8] = msg_bytes[base + k];
      send_chunk(v, c == nch - 1, 10'(cnt * 8));
    end
    msg_id++;
  endtask

  task automatic fill_random(input int unsigned n);
    msg_bytes.delete();
    for (int unsigned i = 0; i < n; i++) msg_bytes.push_back(8'($urandom()));
  endtask

  task automatic fill_abc();
    msg_bytes.delete();
    msg_bytes.push_back(8'h61);
    msg_bytes.push_back(8'h62);
    msg_bytes.push_back(8'h63);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_len_q.size() != 0 || core_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", n < 3000, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned d0, s0, n, sel;
    int unsigned sp[8];
    sp = '{0, 55, 56, 63, 64, 119, 120, 127};
    h_rst_n = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_bits  = '0;
    s_data  = '0;
    do_reset();

    // "abc": single padded block, first and last.
    d0 = done_cnt;
    fill_abc();
    send_msg();
    s_valid = 1'b0;
    drain();
    check_eq("abc_done_count", done_cnt - d0, 1);

    // 60 bytes: two padded blocks with a second-block request in between.
    d0 = done_cnt;
    s0 = pad_s_cnt;
    msg_bytes.delete();
    for (int unsigned i = 0; i < 60; i++) msg_bytes.push_back(8'h41 + 8'(i % 6));
    send_msg();
    s_valid = 1'b0;
    drain();
    check_eq("af60_s_rst_pulses", pad_s_cnt - s0, 1);
    check_eq("af60_done_count", done_cnt - d0, 1);

    // Two full chunks: two raw blocks and a padder block on an empty tail.
    fill_random(128);
    send_msg();
    s_valid = 1'b0;
    drain();

    // Back-to-back "abc" with s_valid held high throughout.
    d0 = done_cnt;
    fill_abc();
    send_msg();
    fill_abc();
    send_msg();
    s_valid = 1'b0;
    drain();
    check_eq("b2b_done_count", done_cnt - d0, 2);

    // Random lengths, biased towards padding boundaries.
    for (int unsigned t = 0; t < 14; t++) begin
      sel = $urandom_range(0, 11);
      n = (sel < 8) ? sp[sel] : $urandom_range(1, 200);
      fill_random(n);
      send_msg();
      if ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    s_valid = 1'b0;
    drain();

    // Reset while waiting on a slow padder; its late answer must be ignored.
    pad_extra = 10;
    fill_random(3);
    send_msg();
    s_valid = 1'b0;
    n = 0;
    while (!pad_h_rst && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrst_pad_load_seen", pad_h_rst, 1'b1);
    repeat (3) @(negedge clk);
    do_reset();
    pad_extra = 0;
    repeat (15) @(negedge clk);
    d0 = done_cnt;
    fill_abc();
    send_msg();
    s_valid = 1'b0;
    drain();
    check_eq("midrst_done_count", done_cnt - d0, 1);

    // Padder never answers: err after the timeout, sticky until reset.
    pad_stuck = 1'b1;
    d0 = done_cnt;
    fill_random(3);
    send_msg();
    s_valid = 1'b0;
    n = 0;
    while (!pad_h_rst && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_pad_load_seen", pad_h_rst, 1'b1);
    n = 0;
    while (!err && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_err_window", (n >= PAD_TIMEOUT) && (n <= PAD_TIMEOUT + 2), 1'b1);
    repeat (20) @(negedge clk);
    check_eq("tmo_err_sticky", err, 1'b1);
    check_eq("tmo_no_done", done_cnt - d0, 0);
    pad_stuck = 1'b0;
    do_reset();

    // Short non-final chunk: err, chunk dropped, nothing reaches the core.
    d0 = done_cnt;
    fill_random(32);
    s_data = '0;
    for (int unsigned k = 0; k < 32; k++) s_data[8*k +: 8] = msg_bytes[k];
    send_chunk(s_data, 1'b0, 10'd256);
    check_eq("badbits_err", err, 1'b1);
    s_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("badbits_err_sticky", err, 1'b1);
    check_eq("badbits_no_done", done_cnt - d0, 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
